apb_spi_nor_bridge: RTL and testbench
=====================================

APB_SPI_NOR_BRIDGE -- requirements
Module: apb_spi_nor_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SPI half-period in p_clk cycles, legal range >= 1.
REQ-002 SHALL have parameter ADDR_BYTES, default 3: flash address bytes sent, legal values 3 or 4.
REQ-003 SHALL have parameter DATA_BYTES, default 4: data bytes per access, legal range 1..4.
REQ-004 SHALL have parameter SPI_MODE, default 0: legal values 0 (s_clk idles low) or 3 (s_clk idles high).
REQ-005 SHALL have parameter CS_GAP, default 4: minimum p_clk cycles s_css stays high between two SPI frames.
REQ-006 SHALL have port p_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-007 SHALL have port p_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port p_addr, input, 32 bits: APB byte address.
REQ-009 SHALL have port p_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port p_sel_x, input, 1 bit: APB select.
REQ-011 SHALL have port p_enable, input, 1 bit: APB access phase.
REQ-012 SHALL have port p_wdata, input, 32 bits: write data.
REQ-013 SHALL have port p_rdata, output, 32 bits: read data.
REQ-014 SHALL have port p_ready, output, 1 bit: transfer complete.
REQ-015 SHALL have port p_slverr, output, 1 bit: error response.
REQ-016 SHALL have port s_clk, output, 1 bit: SPI serial clock.
REQ-017 SHALL have port s_css, output, 1 bit: flash chip select, active-low.
REQ-018 SHALL have port s_mosi, output, 1 bit: serial data to flash.
REQ-019 SHALL have port s_miso, input, 1 bit: serial data from flash.

Function
REQ-020 SHALL start an access in the first cycle (cycle 0) with p_sel_x=1, p_enable=1, FSM in IDLE.
REQ-021 SHALL assert p_slverr and p_ready together for exactly one cycle at cycle 1, with no SPI activity, when p_addr[31:8*ADDR_BYTES] != 0 (ADDR_BYTES=3 only).
REQ-022 SHALL run reads as one frame: opcode 0x03, address bytes MSB first, then DATA_BYTES bytes clocked in.
REQ-023 SHALL run writes as two frames: 0x06 (WREN); s_css high for CS_GAP cycles; then 0x02, address bytes MSB first, then DATA_BYTES bytes from p_wdata.
REQ-024 SHALL send and receive data bytes lowest byte first (p_wdata[7:0] first; first received byte goes to p_rdata[7:0]), each byte MSB first.
REQ-025 SHALL zero p_rdata bits above 8*DATA_BYTES.
REQ-026 SHALL use FSM states IDLE -> (WREN -> GAP ->) XFER -> DONE -> IDLE; reads skip WREN and GAP.
REQ-027 SHALL drive s_css low at cycle 1, and in every frame start.
REQ-028 SHALL make each bit last 2*CLK_DIV cycles; first s_mosi bit valid when s_css falls.
REQ-029 SHALL sample s_miso on the s_clk rising edge and change s_mosi on the falling edge, for both modes.
REQ-030 SHALL return s_clk to its idle level before s_css rises.
REQ-031 SHALL deassert s_css in the cycle after the last bit period ends.
REQ-032 SHALL assert p_ready for one cycle (DONE) in the cycle after s_css rises: read at cycle 2 + 2*CLK_DIV*NBITS, NBITS = 8*(1+ADDR_BYTES+DATA_BYTES).
REQ-033 SHALL keep p_ready=0 at all other times; p_rdata holds its value until the next read completes.
REQ-034 SHALL complete an in-flight SPI frame if p_sel_x drops mid-access, suppress the p_ready pulse, and return to IDLE.
REQ-035 SHALL NOT start a new access in the DONE cycle; the earliest next start is the following cycle, with s_css high for >= CS_GAP cycles between frames.

Reset
REQ-036 SHALL, with p_rst=1, at the next edge set: FSM IDLE; s_css=1; s_clk at idle level; s_mosi=0; p_ready=0; p_slverr=0; p_rdata=0; all counters 0.
REQ-037 SHALL abort any transfer mid-frame on reset with no p_ready pulse.

Structure
REQ-038 SHALL place opcodes (0x03, 0x02, 0x06) and the FSM state encoding in shared package spi_nor_pkg.
REQ-039 SHALL use one sub-module spi_shift_engine (divider, bit counter, shift register, s_clk/s_mosi/s_miso), started and reporting done to the APB FSM.

Verification (CLK_DIV=2, ADDR_BYTES=3, DATA_BYTES=4, mode 0 unless stated)
REQ-040 SHALL cover read: read 0x00012345, flash returns A1 B2 C3 D4 -> s_mosi 03 01 23 45; p_rdata=0xD4C3B2A1; p_ready at cycle 258.
REQ-041 SHALL cover write: write 0x000000FF, data 0x11223344 -> frame 06; s_css high >= 4 cycles; frame 02 00 00 FF 44 33 22 11; one p_ready.
REQ-042 SHALL cover range error: read 0x01000000 -> p_slverr=p_ready=1 at cycle 1; s_css stays high.
REQ-043 SHALL cover SPI_MODE=3: repeat the read test -> s_clk idles high; same p_rdata and latency.
REQ-044 SHALL cover reset mid-frame: p_rst=1 at cycle 100 of a read -> s_css=1 next cycle, no p_ready; a new read then succeeds.
REQ-045 SHALL cover back-to-back: two reads with no idle cycle -> s_css high >= 4 cycles between them; both p_rdata values correct.

Source files
------------

// File: rtl/spi_nor_pkg.sv
// Shared definitions for the APB to SPI NOR flash bridge.
// Holds the flash opcodes, the bridge FSM state encoding and the widest frame size
// the shift engine has to carry (opcode + 4 address bytes + 4 data bytes).
package spi_nor_pkg;

    localparam logic [7:0] OpRead    = 8'h03;
    localparam logic [7:0] OpProgram = 8'h02;
    localparam logic [7:0] OpWren    = 8'h06;

    localparam int unsigned MaxFrameBits = 72;

    typedef enum logic [2:0] {
        StIdle,
        StWren,
        StGap,
        StXfer,
        StDone
    } bridge_state_e;

    // Number of bits in a command frame: opcode, address bytes, data bytes.
    function automatic logic [6:0] frame_bits(int unsigned addr_bytes, int unsigned data_bytes);
        return 7'(8 * (1 + addr_bytes + data_bytes));
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI frame engine: clock divider, bit counter, shift registers and pin timing.
// A frame is loaded on start_i (left-aligned in tx_i, MSB first) and s_css falls the
// next cycle with the first bit already on s_mosi. Each bit lasts 2*CLK_DIV cycles:
// s_clk low for the first half, high for the second; s_miso is sampled on the rising
// edge and s_mosi advances on the falling edge. After the last bit s_css rises, s_clk
// is at its idle level and done_o pulses for one cycle. ready_o stays low until s_css
// has been high long enough that a start gives at least CS_GAP high cycles.
// Ports:
//   p_clk, p_rst       clock, synchronous active-high reset
//   start_i            load tx_i/nbits_i and begin a frame (honoured only when ready_o)
//   nbits_i, tx_i      frame length in bits, frame contents (MSB first from bit 71)
//   ready_o, done_o    idle and past chip-select gap; frame finished pulse
//   rx_o               last 32 bits received, newest in bit 0
//   s_clk_o, s_css_o, s_mosi_o, s_miso_i   SPI pins
module spi_shift_engine
    import spi_nor_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SPI_MODE = 0,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic                    p_clk,
    input  logic                    p_rst,
    input  logic                    start_i,
    input  logic [6:0]              nbits_i,
    input  logic [MaxFrameBits-1:0] tx_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [31:0]             rx_o,
    output logic                    s_clk_o,
    output logic                    s_css_o,
    output logic                    s_mosi_o,
    input  logic                    s_miso_i
);

    localparam logic [15:0] HalfLast = 16'(CLK_DIV - 1);
    localparam logic [15:0] BitLast  = 16'(2 * CLK_DIV - 1);
    // The frame-end cycle already counts as one high cycle of the gap.
    localparam logic [15:0] GapLoad  = 16'((CS_GAP > 0) ? CS_GAP - 1 : 0);
    localparam logic        SclkIdle = (SPI_MODE == 3);

    logic                    busy_q, busy_d;
    logic [15:0]             div_q, div_d;
    logic [15:0]             gap_q, gap_d;
    logic [6:0]              bit_q, bit_d;
    logic [6:0]              nbits_q, nbits_d;
    logic [MaxFrameBits-1:0] shift_q, shift_d;
    logic [31:0]             rx_q, rx_d;
    logic                    sclk_q, sclk_d;
    logic                    css_q, css_d;
    logic                    done_q, done_d;

    assign ready_o  = !busy_q && (gap_q == 16'd0);
    assign done_o   = done_q;
    assign rx_o     = rx_q;
    assign s_clk_o  = sclk_q;
    assign s_css_o  = css_q;
    assign s_mosi_o = shift_q[MaxFrameBits-1];

    always_comb begin
        busy_d  = busy_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        css_d   = css_q;
        done_d  = 1'b0;

        if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
        end

        if (!busy_q) begin
            if (start_i && ready_o) begin
                busy_d  = 1'b1;
                css_d   = 1'b0;
                sclk_d  = 1'b0;
                shift_d = tx_i;
                nbits_d = nbits_i;
                div_d   = 16'd0;
                bit_d   = 7'd0;
            end
        end else if (div_q == HalfLast) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], s_miso_i};
            div_d  = div_q + 16'd1;
        end else if (div_q == BitLast) begin
            div_d = 16'd0;
            if (bit_q == nbits_q - 7'd1) begin
                busy_d  = 1'b0;
                css_d   = 1'b1;
                sclk_d  = SclkIdle;
                shift_d = '0;
                bit_d   = 7'd0;
                done_d  = 1'b1;
                gap_d   = GapLoad;
            end else begin
                bit_d   = bit_q + 7'd1;
                sclk_d  = 1'b0;
                shift_d = {shift_q[MaxFrameBits-2:0], 1'b0};
            end
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            busy_q  <= 1'b0;
            div_q   <= 16'd0;
            gap_q   <= 16'd0;
            bit_q   <= 7'd0;
            nbits_q <= 7'd0;
            shift_q <= '0;
            rx_q    <= 32'd0;
            sclk_q  <= SclkIdle;
            css_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            css_q   <= css_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/apb_spi_nor_bridge.sv
// APB slave that turns each access into SPI NOR flash commands.
// Read:  one frame 0x03, address (MSB first), DATA_BYTES bytes in.
// Write: frame 0x06 (WREN), chip-select gap, frame 0x02, address, DATA_BYTES bytes out.
// Data bytes travel lowest byte first, each byte MSB first. Addresses that do not fit
// in 3 address bytes get an immediate error response with no SPI activity.
// Ports:
//   p_clk, p_rst                         clock, synchronous active-high reset
//   p_addr, p_write, p_sel_x, p_enable, p_wdata   APB request
//   p_rdata, p_ready, p_slverr           APB response
//   s_clk, s_css, s_mosi, s_miso         SPI flash pins
module apb_spi_nor_bridge
    import spi_nor_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned ADDR_BYTES = 3,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned SPI_MODE   = 0,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic        p_clk,
    input  logic        p_rst,
    input  logic [31:0] p_addr,
    input  logic        p_write,
    input  logic        p_sel_x,
    input  logic        p_enable,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr,
    output logic        s_clk,
    output logic        s_css,
    output logic        s_mosi,
    input  logic        s_miso
);

    localparam logic [6:0] MainBits = frame_bits(ADDR_BYTES, DATA_BYTES);
    localparam logic [6:0] WrenBits = 7'd8;

    bridge_state_e state_q, state_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic [31:0]   rdata_q, rdata_d;

    logic                    eng_start, eng_ready, eng_done;
    logic [6:0]              eng_nbits;
    logic [MaxFrameBits-1:0] eng_tx, main_frame;
    logic [31:0]             eng_rx, rx_data;
    logic                    main_is_write, addr_err;

    // The program frame is only ever launched from the gap state.
    assign main_is_write = (state_q == StGap);
    assign addr_err      = (ADDR_BYTES == 3) && (p_addr[31:24] != 8'h00);

    always_comb begin
        main_frame = '0;
        main_frame[71:64] = main_is_write ? OpProgram : OpRead;
        for (int i = 0; i < int'(ADDR_BYTES); i++) begin
            main_frame[63-8*i -: 8] = p_addr[8*(int'(ADDR_BYTES)-1-i) +: 8];
        end
        if (main_is_write) begin
            for (int i = 0; i < int'(DATA_BYTES); i++) begin
                main_frame[63-8*int'(ADDR_BYTES)-8*i -: 8] = p_wdata[8*i +: 8];
            end
        end
    end

    // The first received data byte sits highest in the engine's shift register.
    always_comb begin
        rx_data = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            rx_data[8*i +: 8] = eng_rx[8*(int'(DATA_BYTES)-1-i) +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        err_d     = err_q;
        abort_d   = abort_q | ~p_sel_x;
        rdata_d   = rdata_q;
        eng_start = 1'b0;
        eng_nbits = MainBits;
        eng_tx    = main_frame;

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                err_d   = 1'b0;
                if (p_sel_x && p_enable && eng_ready) begin
                    write_d = p_write;
                    if (addr_err) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (p_write) begin
                        eng_start = 1'b1;
                        eng_nbits = WrenBits;
                        eng_tx    = {OpWren, 64'h0};
                        state_d   = StWren;
                    end else begin
                        eng_start = 1'b1;
                        state_d   = StXfer;
                    end
                end
            end
            StWren: begin
                if (eng_done) begin
                    state_d = abort_d ? StIdle : StGap;
                end
            end
            StGap: begin
                if (abort_d) begin
                    state_d = StIdle;
                end else if (eng_ready) begin
                    eng_start = 1'b1;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                if (eng_done) begin
                    if (abort_d) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                        if (!write_q) begin
                            rdata_d = rx_data;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
        end
    end

    assign p_ready  = (state_q == StDone);
    assign p_slverr = p_ready && err_q;
    assign p_rdata  = rdata_q;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .SPI_MODE(SPI_MODE),
        .CS_GAP  (CS_GAP)
    ) u_engine (
        .p_clk   (p_clk),
        .p_rst   (p_rst),
        .start_i (eng_start),
        .nbits_i (eng_nbits),
        .tx_i    (eng_tx),
        .ready_o (eng_ready),
        .done_o  (eng_done),
        .rx_o    (eng_rx),
        .s_clk_o (s_clk),
        .s_css_o (s_css),
        .s_mosi_o(s_mosi),
        .s_miso_i(s_miso)
    );

endmodule

// File: tb/tb_apb_spi_nor_bridge.sv
// Directed bench: a mode-0 and a mode-3 bridge share the APB bus; each has its own
// flash model that returns a 32-bit pattern after the 32 command/address bits.
module tb_apb_spi_nor_bridge;

    logic        p_clk = 1'b0;
    logic        p_rst;
    logic [31:0] p_addr;
    logic        p_write;
    logic        p_sel_x;
    logic        p_enable;
    logic [31:0] p_wdata;

    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, err0, err1;
    logic        sclk0, sclk1, css0, css1, mosi0, mosi1;
    logic        miso0 = 1'b0;
    logic        miso1 = 1'b0;

    always #5 p_clk = ~p_clk;

    apb_spi_nor_bridge #(
        .CLK_DIV(2), .ADDR_BYTES(3), .DATA_BYTES(4), .SPI_MODE(0), .CS_GAP(4)
    ) dut0 (
        .p_clk(p_clk), .p_rst(p_rst), .p_addr(p_addr), .p_write(p_write),
        .p_sel_x(p_sel_x), .p_enable(p_enable), .p_wdata(p_wdata),
        .p_rdata(rdata0), .p_ready(rdy0), .p_slverr(err0),
        .s_clk(sclk0), .s_css(css0), .s_mosi(mosi0), .s_miso(miso0)
    );

    apb_spi_nor_bridge #(
        .CLK_DIV(2), .ADDR_BYTES(3), .DATA_BYTES(4), .SPI_MODE(3), .CS_GAP(4)
    ) dut3 (
        .p_clk(p_clk), .p_rst(p_rst), .p_addr(p_addr), .p_write(p_write),
        .p_sel_x(p_sel_x), .p_enable(p_enable), .p_wdata(p_wdata),
        .p_rdata(rdata1), .p_ready(rdy1), .p_slverr(err1),
        .s_clk(sclk1), .s_css(css1), .s_mosi(mosi1), .s_miso(miso1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash model: bits 32..63 of a frame carry flash_data MSB first.
    logic [31:0] flash_data = 32'h0;

    function automatic logic flash_bit(input int i, input logic [31:0] d);
        if (i >= 32 && i < 64) return d[63-i];
        return 1'b0;
    endfunction

    int fb0 = 0;
    int fb1 = 0;

    always @(negedge css0) begin fb0 = 0; miso0 = flash_bit(0, flash_data); end
    always @(negedge css1) begin fb1 = 0; miso1 = flash_bit(0, flash_data); end
    always @(negedge sclk0) if (css0 === 1'b0) miso0 = flash_bit(fb0, flash_data);
    always @(negedge sclk1) if (css1 === 1'b0) miso1 = flash_bit(fb1, flash_data);
    always @(posedge sclk1) if (css1 === 1'b0) fb1++;

    // Mode-0 frame capture on s_clk rising edges, recorded when s_css rises.
    logic [71:0] cap0 = 72'h0;
    int          capn0 = 0;
    logic [71:0] frames [0:31];
    int          fbits [0:31];
    int          nfr = 0;

    always @(posedge sclk0) begin
        if (css0 === 1'b0) begin
            cap0 = {cap0[70:0], mosi0};
            capn0++;
            fb0++;
        end
    end

    always @(posedge css0) begin
        fb0 = 0;
        if (capn0 > 0 && nfr < 32) begin
            frames[nfr] = cap0;
            fbits[nfr]  = capn0;
            nfr++;
        end
        cap0  = 72'h0;
        capn0 = 0;
    end

    // Length of the most recent s_css high stretch, and p_ready pulse count.
    int hi_cnt = 0;
    int last_gap = 0;
    int rdy_cnt0 = 0;

    always @(negedge p_clk) begin
        if (css0 === 1'b1) begin
            hi_cnt++;
        end else begin
            if (hi_cnt != 0) last_gap = hi_cnt;
            hi_cnt = 0;
        end
        if (rdy0 === 1'b1) rdy_cnt0++;
    end

    int          lat0, lat1;
    logic [31:0] rd0, rd1;
    logic        er0, er1;

    // One APB access: setup cycle, then access phase (cycle 0) until both bridges respond.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] resp, input bit keep_sel);
        int n;
        @(posedge p_clk); #1;
        p_sel_x = 1'b1; p_enable = 1'b0; p_write = wr; p_addr = addr; p_wdata = wdata;
        flash_data = resp;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        lat0 = -1; lat1 = -1; rd0 = 'x; rd1 = 'x; er0 = 1'bx; er1 = 1'bx;
        n = 0;
        while ((lat0 < 0 || lat1 < 0) && n < 2000) begin
            @(negedge p_clk);
            if (rdy0 === 1'b1 && lat0 < 0) begin lat0 = n; rd0 = rdata0; er0 = err0; end
            if (rdy1 === 1'b1 && lat1 < 0) begin lat1 = n; rd1 = rdata1; er1 = err1; end
            n++;
        end
        @(posedge p_clk); #1;
        p_enable = 1'b0;
        if (!keep_sel) p_sel_x = 1'b0;
    endtask

    int nf;
    int rc;

    initial begin
        p_rst = 1'b1; p_sel_x = 1'b0; p_enable = 1'b0; p_write = 1'b0;
        p_addr = 32'h0; p_wdata = 32'h0;
        repeat (3) @(posedge p_clk);
        #1 p_rst = 1'b0;
        @(negedge p_clk);
        check("reset_css0", 72'(css0), 72'h1);
        check("reset_css3", 72'(css1), 72'h1);
        check("reset_sclk0_idle_low", 72'(sclk0), 72'h0);
        check("reset_sclk3_idle_high", 72'(sclk1), 72'h1);
        check("reset_mosi", 72'({mosi0, mosi1}), 72'h0);
        check("reset_ready_err", 72'({rdy0, err0, rdy1, err1}), 72'h0);
        check("reset_rdata", 72'({rdata0, rdata1}), 72'h0);

        // Plain read.
        rc = rdy_cnt0; nf = nfr;
        apb_xfer(1'b0, 32'h0001_2345, 32'h0, 32'hA1B2_C3D4, 1'b0);
        check("read_latency", 72'(lat0), 72'd258);
        check("read_rdata", 72'(rd0), 72'hD4C3_B2A1);
        check("read_slverr", 72'(er0), 72'h0);
        check("read_frames", 72'(nfr - nf), 72'd1);
        check("read_frame_bits", 72'(fbits[nf]), 72'd64);
        check("read_frame_mosi", frames[nf] & 72'hFF_FFFF_FFFF_FFFF_FFFF, 72'h03_0123_4500_0000_00);
        check("read_ready_pulses", 72'(rdy_cnt0 - rc), 72'd1);
        check("mode3_latency", 72'(lat1), 72'd258);
        check("mode3_rdata", 72'(rd1), 72'hD4C3_B2A1);
        check("mode3_sclk_idle", 72'(sclk1), 72'h1);
        check("mode0_sclk_idle", 72'(sclk0), 72'h0);

        // Write: WREN frame, gap, program frame.
        rc = rdy_cnt0; nf = nfr;
        apb_xfer(1'b1, 32'h0000_00FF, 32'h1122_3344, 32'h0, 1'b0);
        check("write_frames", 72'(nfr - nf), 72'd2);
        check("wren_bits", 72'(fbits[nf]), 72'd8);
        check("wren_opcode", frames[nf] & 72'hFF, 72'h06);
        check("program_bits", 72'(fbits[nf+1]), 72'd64);
        check("program_mosi", frames[nf+1] & 72'hFF_FFFF_FFFF_FFFF_FFFF, 72'h02_0000_FF44_3322_11);
        check("write_cs_gap", 72'(last_gap >= 4), 72'h1);
        check("write_ready_pulses", 72'(rdy_cnt0 - rc), 72'd1);
        check("write_slverr", 72'(er0), 72'h0);
        check("write_keeps_rdata", 72'(rdata0), 72'hD4C3_B2A1);

        // Out-of-range address.
        nf = nfr;
        apb_xfer(1'b0, 32'h0100_0000, 32'h0, 32'h0, 1'b0);
        check("err_latency", 72'(lat0), 72'd1);
        check("err_slverr", 72'(er0), 72'h1);
        check("err_no_frame", 72'(nfr - nf), 72'd0);

        // Reset in the middle of a read frame.
        rc = rdy_cnt0;
        flash_data = 32'h5555_AAAA;
        @(posedge p_clk); #1;
        p_sel_x = 1'b1; p_enable = 1'b0; p_write = 1'b0; p_addr = 32'h0001_2345;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        repeat (100) @(posedge p_clk);
        #1 p_rst = 1'b1; p_sel_x = 1'b0; p_enable = 1'b0;
        @(posedge p_clk); #1 p_rst = 1'b0;
        @(negedge p_clk);
        check("rst_mid_css", 72'({css0, css1}), 72'h3);
        check("rst_mid_sclk", 72'({sclk0, sclk1}), 72'h1);
        check("rst_mid_rdata", 72'(rdata0), 72'h0);
        repeat (300) @(negedge p_clk);
        check("rst_mid_no_ready", 72'(rdy_cnt0 - rc), 72'd0);
        apb_xfer(1'b0, 32'h0001_2345, 32'h0, 32'hA1B2_C3D4, 1'b0);
        check("rst_then_read_lat", 72'(lat0), 72'd258);
        check("rst_then_read_rdata", 72'({rd0, rd1}), 72'hD4C3_B2A1_D4C3_B2A1);

        // Back-to-back reads with p_sel_x held high between them.
        nf = nfr;
        apb_xfer(1'b0, 32'h0000_1000, 32'h0, 32'h1234_5678, 1'b1);
        check("b2b_first_rdata", 72'({rd0, rd1}), 72'h7856_3412_7856_3412);
        apb_xfer(1'b0, 32'h00AB_CDEF, 32'h0, 32'h5A6B_7C8D, 1'b0);
        check("b2b_second_rdata", 72'({rd0, rd1}), 72'h8D7C_6B5A_8D7C_6B5A);
        check("b2b_cs_gap", 72'(last_gap >= 4), 72'h1);
        check("b2b_second_mosi", frames[nf+1] & 72'hFF_FFFF_FFFF_FFFF_FFFF,
              72'h03_ABCD_EF00_0000_00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
